// File: rtl/mdu_def.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller state encoding and default latencies.
package mdu_def;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: computes the result at start, holds it in temp
// registers for the modelled latency, then commits it to HI/LO.
module mdu_ctrl
  import mdu_def::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        op_err
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

  mdu_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]    tmp_hi;
  logic [31:0]    tmp_lo;
  logic           div_by_zero;

  md_op_e         op;
  logic [63:0]    prod_s;
  logic [63:0]    prod_u;
  logic [31:0]    quot_s;
  logic [31:0]    rem_s;
  logic [31:0]    quot_u;
  logic [31:0]    rem_u;
  logic           b_zero;

  assign op     = md_op_e'(md_op);
  assign b_zero = (b == 32'd0);

  // Division is guarded so a zero divisor never produces undefined values.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!b_zero) begin
      quot_s = $signed(a) / $signed(b);
      rem_s  = $signed(a) % $signed(b);
      quot_u = a / b;
      rem_u  = a % b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmp_hi      <= 32'd0;
      tmp_lo      <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      op_err      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      op_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT: begin
                {tmp_hi, tmp_lo} <= prod_s;
                div_by_zero      <= 1'b0;
                cnt              <= MULT_LOAD;
                state            <= S_MUL;
                busy             <= 1'b1;
              end
              MD_MULTU: begin
                {tmp_hi, tmp_lo} <= prod_u;
                div_by_zero      <= 1'b0;
                cnt              <= MULT_LOAD;
                state            <= S_MUL;
                busy             <= 1'b1;
              end
              MD_DIV: begin
                if (!b_zero) begin
                  tmp_lo <= quot_s;
                  tmp_hi <= rem_s;
                end
                div_by_zero <= b_zero;
                cnt         <= DIV_LOAD;
                state       <= S_DIV;
                busy        <= 1'b1;
              end
              MD_DIVU: begin
                if (!b_zero) begin
                  tmp_lo <= quot_u;
                  tmp_hi <= rem_u;
                end
                div_by_zero <= b_zero;
                cnt         <= DIV_LOAD;
                state       <= S_DIV;
                busy        <= 1'b1;
              end
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        // An overlapping start means the hazard logic failed to stall; flag and drop it.
        S_MUL, S_DIV: begin
          if (start) begin
            op_err <= 1'b1;
          end
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!div_by_zero) begin
              hi <= tmp_hi;
              lo <= tmp_lo;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes model-predicted commits,
// a monitor pops them whenever the DUT commits HI/LO.
module tb_mdu_ctrl;
  import mdu_def::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    string       name;
    int          nbusy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        op_err;

  exp_t        exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks;
  int          errors;
  int          exp_err;
  int          seen_err;

  mdu_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .op_err (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic string op_name(input logic [2:0] op);
    case (op)
      3'd0: return "mult";
      3'd1: return "multu";
      3'd2: return "div";
      3'd3: return "divu";
      3'd4: return "mthi";
      3'd5: return "mtlo";
      default: return "rsvd";
    endcase
  endfunction

  // Architectural model: what HI/LO become and how long busy lasts.
  task automatic model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output int nbusy, output logic [31:0] nhi, output logic [31:0] nlo);
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    nbusy = 0;
    nhi   = m_hi;
    nlo   = m_lo;
    case (op)
      3'd0: begin
        p = longint'($signed(av)) * longint'($signed(bv));
        nhi = p[63:32];
        nlo = p[31:0];
        nbusy = MULT_N;
      end
      3'd1: begin
        pu = {32'd0, av} * {32'd0, bv};
        nhi = pu[63:32];
        nlo = pu[31:0];
        nbusy = MULT_N;
      end
      3'd2: begin
        nbusy = DIV_N;
        if (bv != 0) begin
          sa = $signed(av);
          sb = $signed(bv);
          nlo = sa / sb;
          nhi = sa % sb;
        end
      end
      3'd3: begin
        nbusy = DIV_N;
        if (bv != 0) begin
          nlo = av / bv;
          nhi = av % bv;
        end
      end
      3'd4: nhi = av;
      3'd5: nlo = av;
      default: ;
    endcase
  endtask

  // Issues one op from posedge+1 and returns at posedge+1 of the first cycle it may issue again.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                input bit use_lit, input logic [31:0] lit_hi, input logic [31:0] lit_lo,
                                input bit overlap, input logic [2:0] ov_op);
    int          nbusy;
    logic [31:0] nhi;
    logic [31:0] nlo;
    exp_t        e;
    model(op, av, bv, nbusy, nhi, nlo);
    if (use_lit) begin
      nhi = lit_hi;
      nlo = lit_lo;
    end
    if (op <= 3'd5) begin
      e.name  = op_name(op);
      e.nbusy = nbusy;
      e.hi    = nhi;
      e.lo    = nlo;
      exp_q.push_back(e);
      m_hi = nhi;
      m_lo = nlo;
    end
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (nbusy > 0) begin
      if (overlap) begin
        start = 1'b1;
        md_op = ov_op;
        a     = $urandom;
        b     = $urandom;
        exp_err++;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (nbusy - 1) @(posedge clk);
      end else begin
        repeat (nbusy) @(posedge clk);
      end
      #1;
    end
  endtask

  task automatic pop_and_check(input int run);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_commit: actual hi=0x%08h lo=0x%08h required no commit", hi, lo);
    end else begin
      e = exp_q.pop_front();
      check_output({e.name, "_hi"}, hi, e.hi);
      check_output({e.name, "_lo"}, lo, e.lo);
      check_output({e.name, "_busy_cycles"}, 32'(run), 32'(e.nbusy));
    end
  endtask

  // Monitor: a commit is either busy falling, or an mthi/mtlo accepted while idle.
  initial begin
    int          run;
    bit          prev_busy;
    bit          pend;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    run = 0;
    prev_busy = 1'b0;
    pend = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0;
        prev_busy = 1'b0;
        pend = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
      end else begin
        if (op_err) seen_err++;
        if (pend) begin
          pop_and_check(int'(busy));
          cur_hi = hi;
          cur_lo = lo;
        end
        if (busy) begin
          run++;
          if (run == 1) begin
            check_output("held_hi", hi, cur_hi);
            check_output("held_lo", lo, cur_lo);
          end
        end else if (prev_busy) begin
          pop_and_check(run);
          cur_hi = hi;
          cur_lo = lo;
          run = 0;
        end
        pend = start && !busy && (md_op == MD_MTHI || md_op == MD_MTLO);
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    checks = 0;
    errors = 0;
    exp_err = 0;
    seen_err = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    #3;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    check_output("reset_op_err", 32'(op_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(MD_MULT,  32'hFFFFFFFE, 32'd3,        1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 3'd0);
    apply_stimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 3'd0);
    apply_stimulus(MD_DIV,   32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 3'd0);
    apply_stimulus(MD_MTHI,  32'h1234, 32'd0, 0, 32'd0, 32'd0, 0, 3'd0);
    apply_stimulus(MD_MTLO,  32'h1234, 32'd0, 0, 32'd0, 32'd0, 0, 3'd0);
    apply_stimulus(MD_DIVU,  32'hCAFE, 32'd0, 1, 32'h1234, 32'h1234, 0, 3'd0);
    apply_stimulus(MD_MTHI,  32'hDEADBEEF, 32'd0, 1, 32'hDEADBEEF, 32'h1234, 0, 3'd0);
    apply_stimulus(MD_MULT,  32'd5, 32'd6, 1, 32'd0, 32'd30, 1, MD_MTLO);
    apply_stimulus(MD_DIV,   32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 3'd0);
    apply_stimulus(MD_MULT,  32'd3, 32'd4, 1, 32'd0, 32'd12, 0, 3'd0);

    // Reset in the third busy cycle of a divide: the divide is abandoned.
    start = 1'b1;
    md_op = MD_DIV;
    a = 32'hFFFFFFF9;
    b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_hi", hi, 32'd0);
    check_output("midreset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(MD_MULT, 32'd2, 32'd2, 1, 32'd0, 32'd4, 0, 3'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0: bv = 32'd0;
        1: bv = 32'hFFFFFFFF;
        2: bv = 32'($urandom_range(1, 9));
        default: bv = $urandom;
      endcase
      if (op == MD_DIV && av == 32'h80000000 && bv == 32'hFFFFFFFF) bv = 32'd1;
      apply_stimulus(op, av, bv, 0, 32'd0, 32'd0, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 5)));
    end

    repeat (5) @(posedge clk);
    #1;
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("op_err_pulses", 32'(seen_err), 32'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
